// File: rtl/synch_down_counter.sv
// -----------------------------------------------------------------------------
// synch_down_counter
//
// Loadable down-counter with a one-shot or periodic (auto-reload) mode and a
// registered terminal-count pulse. A two-state controller (IDLE/RUN) decides
// whether enable pulses are accepted. All outputs come straight from flops.
//
// Parameters
//   n            counter width in bits (2..32)
//
// Ports
//   clk          single clock, all state changes on its rising edge
//   reset_n      synchronous active-low reset (wins over load and en)
//   en           count enable, one decrement per edge while in RUN
//   load         parallel-load strobe: captures d into Q and the reload reg
//   d            load value
//   auto_reload  1 = reload on terminal count (periodic), 0 = stop (one-shot)
//   Q            current count
//   tc           one-cycle terminal-count pulse
//   busy         high while in RUN
// -----------------------------------------------------------------------------
module synch_down_counter #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         load,
  input  logic [n-1:0] d,
  input  logic         auto_reload,
  output logic [n-1:0] Q,
  output logic         tc,
  output logic         busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [n-1:0] CountOne  = n'(1);
  localparam logic [n-1:0] CountZero = '0;

  state_e       state_q, state_d;
  logic [n-1:0] count_q, count_d;
  logic [n-1:0] reload_q, reload_d;
  logic         tc_q, tc_d;

  // Next-state and next-output logic.
  // NOTE: every variable assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (load) begin
      // Load overrides counting, including a coincident terminal count.
      count_d  = d;
      reload_d = d;
      state_d  = (d != CountZero) ? RUN : IDLE;
    end else if (state_q == RUN && en) begin
      if (count_q > CountOne) begin
        count_d = count_q - CountOne;
      end else if (count_q == CountOne) begin
        // Terminal count: auto_reload matters only in this cycle.
        tc_d = 1'b1;
        if (auto_reload) begin
          count_d = reload_q;
        end else begin
          count_d = CountZero;
          state_d = IDLE;
        end
      end else begin
        // RUN with a zero count is unreachable (a zero load enters IDLE);
        // fall back to IDLE rather than wrapping below zero.
        state_d = IDLE;
      end
    end
  end

  // State register with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      count_q  <= CountZero;
      reload_q <= CountZero;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign Q    = count_q;
  assign tc   = tc_q;
  assign busy = (state_q == RUN);

endmodule

// File: tb/tb_synch_down_counter.sv
// -----------------------------------------------------------------------------
// tb_synch_down_counter
//
// Directed scenarios followed by a randomized run, all compared against a
// behavioural model that applies the counter's rules with plain integers.
// -----------------------------------------------------------------------------
module tb_synch_down_counter;

  localparam int N = 4;
  localparam int MASK = (1 << N) - 1;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         en;
  logic         load;
  logic [N-1:0] d;
  logic         auto_reload;
  logic [N-1:0] q_o;
  logic         tc_o;
  logic         busy_o;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int m_q      = 0;
  int m_reload = 0;
  bit m_run    = 0;
  bit m_tc     = 0;

  synch_down_counter #(.n(N)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .load        (load),
    .d           (d),
    .auto_reload (auto_reload),
    .Q           (q_o),
    .tc          (tc_o),
    .busy        (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Behavioural reference: apply one rising edge of the counter's rules.
  task automatic model_edge();
    if (!reset_n) begin
      m_q = 0; m_reload = 0; m_tc = 0; m_run = 0;
    end else if (load) begin
      m_q = int'(d); m_reload = int'(d); m_tc = 0; m_run = (d != 0);
    end else if (m_run && en) begin
      if (m_q == 1) begin
        m_tc = 1;
        if (auto_reload) m_q = m_reload;
        else begin m_q = 0; m_run = 0; end
      end else begin
        m_q  = (m_q - 1) & MASK;
        m_tc = 0;
      end
    end else begin
      m_tc = 0;
    end
  endtask

  // One clock: advance the model at the edge, then compare 1 time unit later.
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, ".Q"},    int'(q_o),    m_q);
    check({tag, ".tc"},   int'(tc_o),   int'(m_tc));
    check({tag, ".busy"}, int'(busy_o), int'(m_run));
  endtask

  task automatic drive(input bit r, input bit l, input int dv, input bit e, input bit ar);
    reset_n = r; load = l; d = dv[N-1:0]; en = e; auto_reload = ar;
  endtask

  int exp_seq[6];

  initial begin
    drive(0, 0, 0, 0, 0);

    // Reset, with load and en both asserted to show reset wins.
    drive(0, 1, 7, 1, 0);
    tick("reset");
    check("reset_const.Q", int'(q_o), 0);
    check("reset_const.busy", int'(busy_o), 0);

    // One-shot count from 5.
    exp_seq = '{5, 4, 3, 2, 1, 0};
    drive(1, 1, 5, 1, 0);
    tick("oneshot_load");
    check("oneshot_seq0", int'(q_o), exp_seq[0]);
    drive(1, 0, 0, 1, 0);
    for (int i = 1; i < 6; i++) begin
      tick("oneshot");
      check("oneshot_seq", int'(q_o), exp_seq[i]);
    end
    check("oneshot_tc_at_zero", int'(tc_o), 1);
    check("oneshot_busy_fell", int'(busy_o), 0);
    for (int i = 0; i < 3; i++) tick("oneshot_hold");
    check("oneshot_q_stays_0", int'(q_o), 0);

    // Periodic count from 3.
    drive(1, 1, 3, 1, 1);
    tick("periodic_load");
    drive(1, 0, 0, 1, 1);
    for (int i = 0; i < 9; i++) tick("periodic");
    check("periodic_end_q", int'(q_o), 3);

    // Enable toggling: 6,5,5,5,4,3 with no tc.
    drive(1, 1, 6, 1, 0);
    tick("gate_load");
    foreach (exp_seq[i]) exp_seq[i] = 0;
    begin
      bit en_pat[5] = '{1, 0, 0, 1, 1};
      foreach (en_pat[i]) begin
        drive(1, 0, 0, en_pat[i], 0);
        tick("gate");
      end
    end
    check("gate_end_q", int'(q_o), 3);

    // Load coinciding with terminal count.
    drive(1, 1, 4, 1, 0);
    tick("tcload_load");
    drive(1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) tick("tcload_count");
    check("tcload_at_1", int'(q_o), 1);
    drive(1, 1, 9, 1, 0);
    tick("tcload_coincide");
    check("tcload_q9", int'(q_o), 9);
    check("tcload_no_tc", int'(tc_o), 0);
    check("tcload_busy", int'(busy_o), 1);

    // Reset mid-count at Q=10.
    drive(1, 1, 15, 1, 0);
    tick("midreset_load");
    drive(1, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) tick("midreset_count");
    check("midreset_at_10", int'(q_o), 10);
    drive(0, 0, 0, 1, 0);
    tick("midreset_reset");
    drive(1, 0, 0, 1, 1);
    for (int i = 0; i < 3; i++) tick("midreset_after");
    check("midreset_q0", int'(q_o), 0);

    // Zero load, then reload value 1 in periodic mode.
    drive(1, 1, 0, 1, 1);
    tick("zero_load");
    check("zero_busy", int'(busy_o), 0);
    drive(1, 1, 1, 1, 1);
    tick("r1_load");
    drive(1, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      tick("r1");
      check("r1_tc_const", int'(tc_o), 1);
    end

    // Maximum load value and a randomized run.
    drive(1, 1, MASK, 1, 0);
    tick("max_load");
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 39) != 0),
            ($urandom_range(0, 11) == 0),
            int'($urandom_range(0, MASK)),
            ($urandom_range(0, 3) != 0),
            $urandom_range(0, 1) == 1);
      tick("random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
